// File: rtl/tdc_frame_pkg.sv
// Shared constants and state encodings for the TDC record deframer.
package tdc_frame_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] TYPE_DATA   = 8'h01;
    localparam logic [7:0] TYPE_LINE   = 8'h02;
    localparam logic [7:0] TYPE_FRAME  = 8'h03;
    localparam int         PAYLOAD_LEN = 6;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        TYPE    = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchronizer, start-bit glitch rejection,
// centre sampling of 8 data bits (LSB first) and a stop-bit check.
module uart_byte_rx
    import tdc_frame_pkg::*;
#(
    parameter int CLK_PER_BIT = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       new_byte_o,
    output logic       stop_err_o,
    output logic       busy_o
);

    localparam int            CW   = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_PER_BIT / 2 - 1);

    logic            sync1_q, sync2_q, prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            new_byte_q, new_byte_d;
    logic            stop_err_q, stop_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            new_byte_q <= 1'b0;
            stop_err_q <= 1'b0;
        end else begin
            sync1_q    <= rx_i;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            new_byte_q <= new_byte_d;
            stop_err_q <= stop_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q + 1'b1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        new_byte_d = 1'b0;
        stop_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !sync2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d      = '0;
                    new_byte_d = sync2_q;
                    stop_err_d = !sync2_q;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign byte_o     = shift_q;
    assign new_byte_o = new_byte_q;
    assign stop_err_o = stop_err_q;
    assign busy_o     = (rx_state_q != RX_IDLE);

endmodule

// File: rtl/tdc_frame_rx.sv
// TDC record deframer: sync/type/payload[/checksum] over 8N1 UART.
// Macro TDC_FRAME_CHECKSUM_EN adds the trailing checksum byte and chk_err.
module tdc_frame_rx
    import tdc_frame_pkg::*;
#(
    parameter int CLK_PER_BIT  = 12,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [47:0] data_out,
    output logic        data_valid,
    output logic        line_marker,
    output logic        frame_marker,
    output logic        chk_err,
    output logic        frame_err,
    output logic [7:0]  err_count,
    output logic [1:0]  dbg_state_o
);

    // All outputs are single-cycle strobes with no ready: a consumer must take
    // every pulse; data_out holds between data_valid strobes.
    localparam int            TO_CYC = TIMEOUT_BITS * CLK_PER_BIT;
    localparam int            TO_W   = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

    logic [7:0] rx_byte;
    logic       new_byte, stop_err, rx_busy;

    uart_byte_rx #(.CLK_PER_BIT(CLK_PER_BIT)) u_byte_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx),
        .byte_o     (rx_byte),
        .new_byte_o (new_byte),
        .stop_err_o (stop_err),
        .busy_o     (rx_busy)
    );

    state_t          state_q, state_d;
    logic [7:0]      type_q, type_d;
    logic [7:0]      xor_q, xor_d;
    logic [2:0]      idx_q, idx_d;
    logic [47:0]     payload_q, payload_d;
    logic [47:0]     data_q, data_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            dv_q, dv_d, lm_q, lm_d, fm_q, fm_d;
    logic            chk_err_q, chk_err_d, frame_err_q, frame_err_d;
    logic            emit;
    logic [47:0]     emit_pl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            type_q      <= '0;
            xor_q       <= '0;
            idx_q       <= '0;
            payload_q   <= '0;
            data_q      <= '0;
            to_cnt_q    <= '0;
            err_cnt_q   <= '0;
            dv_q        <= 1'b0;
            lm_q        <= 1'b0;
            fm_q        <= 1'b0;
            chk_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            xor_q       <= xor_d;
            idx_q       <= idx_d;
            payload_q   <= payload_d;
            data_q      <= data_d;
            to_cnt_q    <= to_cnt_d;
            err_cnt_q   <= err_cnt_d;
            dv_q        <= dv_d;
            lm_q        <= lm_d;
            fm_q        <= fm_d;
            chk_err_q   <= chk_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        xor_d       = xor_q;
        idx_d       = idx_q;
        payload_d   = payload_q;
        data_d      = data_q;
        err_cnt_d   = err_cnt_q;
        dv_d        = 1'b0;
        lm_d        = 1'b0;
        fm_d        = 1'b0;
        chk_err_d   = 1'b0;
        frame_err_d = 1'b0;
        emit        = 1'b0;
        emit_pl     = payload_q;

        // Idle timer only runs between bytes of a frame in progress.
        if (state_q == HUNT || rx_busy) to_cnt_d = '0;
        else                            to_cnt_d = to_cnt_q + 1'b1;

        if (state_q != HUNT && !rx_busy && to_cnt_q == TO_LAST) begin
            frame_err_d = 1'b1;
            state_d     = HUNT;
        end else if (stop_err && state_q != HUNT) begin
            frame_err_d = 1'b1;
            state_d     = HUNT;
        end else if (new_byte) begin
            case (state_q)
                HUNT: if (rx_byte == SYNC_BYTE) state_d = TYPE;
                TYPE: begin
                    if (rx_byte == TYPE_DATA || rx_byte == TYPE_LINE || rx_byte == TYPE_FRAME) begin
                        type_d  = rx_byte;
                        xor_d   = rx_byte;
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = HUNT;
                    end
                end
                PAYLOAD: begin
                    payload_d = {rx_byte, payload_q[47:8]};
                    xor_d     = xor_q ^ rx_byte;
                    if (idx_q == 3'(PAYLOAD_LEN - 1)) begin
                        idx_d = '0;
`ifdef TDC_FRAME_CHECKSUM_EN
                        state_d = CHECK;
`else
                        emit    = 1'b1;
                        emit_pl = payload_d;
                        state_d = HUNT;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (rx_byte == xor_q) emit = 1'b1;
                    else                  chk_err_d = 1'b1;
                    state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end

        if (emit) begin
            case (type_q)
                TYPE_DATA: begin
                    data_d = emit_pl;
                    dv_d   = 1'b1;
                end
                TYPE_LINE:  lm_d = 1'b1;
                TYPE_FRAME: fm_d = 1'b1;
                default: ;
            endcase
        end

        if ((frame_err_d || chk_err_d) && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 1'b1;
    end

    assign data_out     = data_q;
    assign data_valid   = dv_q;
    assign line_marker  = lm_q;
    assign frame_marker = fm_q;
    assign frame_err    = frame_err_q;
    assign err_count    = err_cnt_q;
    assign dbg_state_o  = state_q;
`ifdef TDC_FRAME_CHECKSUM_EN
    assign chk_err      = chk_err_q;
`else
    assign chk_err      = 1'b0;
`endif

endmodule

// File: tb/tb_tdc_frame_rx.sv
// Directed bench for tdc_frame_rx; honours TDC_FRAME_CHECKSUM_EN like the DUT.
module tb_tdc_frame_rx;

    localparam int CPB = 12;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic [47:0] data_out;
    logic        data_valid, line_marker, frame_marker, chk_err, frame_err;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err  = 0;

    int dv_cnt = 0, lm_cnt = 0, fm_cnt = 0, ce_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int s_dv, s_lm, s_fm, s_ce, s_fe;

    tdc_frame_rx #(.CLK_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .line_marker  (line_marker),
        .frame_marker (frame_marker),
        .chk_err      (chk_err),
        .frame_err    (frame_err),
        .err_count    (err_count),
        .dbg_state_o  (dbg_state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (data_valid)   dv_cnt++;
        if (line_marker)  lm_cnt++;
        if (frame_marker) fm_cnt++;
        if (chk_err)      ce_cnt++;
        if (frame_err)    fe_cnt++;
        if (chk_err && frame_err) both_cnt++;
    end

    // driver tasks
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] typ, input logic [47:0] pl, input logic [7:0] chk);
        send_byte(8'hA5, 1'b1);
        send_byte(typ, 1'b1);
        for (int i = 0; i < 6; i++) send_byte(pl[i*8 +: 8], 1'b1);
`ifdef TDC_FRAME_CHECKSUM_EN
        send_byte(chk, 1'b1);
`else
        if (chk == 8'h00) ; // checksum byte is not part of the 8-byte frame
`endif
    endtask

    task automatic snap();
        @(negedge clk);
        s_dv = dv_cnt; s_lm = lm_cnt; s_fm = fm_cnt; s_ce = ce_cnt; s_fe = fe_cnt;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // scenario tasks
    task automatic test_reset();
        rx = 1'b1;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (data_out !== 48'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", data_out); end
        n_checks++; if (err_count !== 8'h0) begin n_fail++; $display("FAIL reset_errcnt: got %0d expected 0", err_count); end
        n_checks++; if ({data_valid, line_marker, frame_marker, chk_err, frame_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b expected 00000",
                               {data_valid, line_marker, frame_marker, chk_err, frame_err}); end
        n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state_o); end
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_data();
        snap();
        send_frame(8'h01, 48'h665544332211, 8'h76);
        idle(20);
        chk_int("data_dv", dv_cnt - s_dv, 1);
        n_checks++; if (data_out !== 48'h665544332211) begin n_fail++; $display("FAIL data_out: got %h expected 665544332211", data_out); end
        chk_int("data_errs", (ce_cnt - s_ce) + (fe_cnt - s_fe), 0);
        chk_int("data_errcnt", err_count, exp_err);
    endtask

    task automatic test_markers();
        snap();
        send_frame(8'h02, 48'h0, 8'h02);
        idle(20);
        chk_int("line_marker", lm_cnt - s_lm, 1);
        chk_int("line_no_fm", fm_cnt - s_fm, 0);
        snap();
        send_frame(8'h03, 48'h0, 8'h03);
        idle(20);
        chk_int("frame_marker", fm_cnt - s_fm, 1);
        chk_int("frame_no_lm", lm_cnt - s_lm, 0);
        n_checks++; if (data_out !== 48'h665544332211) begin n_fail++; $display("FAIL marker_data_hold: got %h expected 665544332211", data_out); end
    endtask

    task automatic test_bad_checksum();
        snap();
        send_frame(8'h01, 48'h665544332211, 8'h77);
        idle(20);
`ifdef TDC_FRAME_CHECKSUM_EN
        exp_err++;
        chk_int("badchk_ce", ce_cnt - s_ce, 1);
        chk_int("badchk_dv", dv_cnt - s_dv, 0);
`else
        chk_int("nochk_ce", ce_cnt - s_ce, 0);
        chk_int("nochk_dv", dv_cnt - s_dv, 1);
`endif
        chk_int("badchk_errcnt", err_count, exp_err);
        snap();
        send_frame(8'h01, 48'h060504030201, 8'h06);
        idle(20);
        chk_int("after_badchk_dv", dv_cnt - s_dv, 1);
        n_checks++; if (data_out !== 48'h060504030201) begin n_fail++; $display("FAIL after_badchk_data: got %h expected 060504030201", data_out); end
    endtask

    task automatic test_noise();
        snap();
        rx = 1'b0;
        repeat (2) @(posedge clk);
        rx = 1'b1;
        idle(30);
        chk_int("glitch_state", dbg_state_o, 0);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        idle(10);
        chk_int("garbage_fe", fe_cnt - s_fe, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h07, 1'b1);
        idle(20);
        exp_err++;
        chk_int("badtype_fe", fe_cnt - s_fe, 1);
        chk_int("badtype_errcnt", err_count, exp_err);
        chk_int("badtype_state", dbg_state_o, 0);
        snap();
        send_frame(8'h01, 48'h123456789ABC, 8'h01 ^ 8'hBC ^ 8'h9A ^ 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12);
        idle(20);
        chk_int("resync_dv", dv_cnt - s_dv, 1);
        n_checks++; if (data_out !== 48'h123456789ABC) begin n_fail++; $display("FAIL resync_data: got %h expected 123456789abc", data_out); end
    endtask

    task automatic test_timeout();
        snap();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle(200);
        chk_int("timeout_early", fe_cnt - s_fe, 0);
        idle(100);
        exp_err++;
        chk_int("timeout_fe", fe_cnt - s_fe, 1);
        chk_int("timeout_dv", dv_cnt - s_dv, 0);
        chk_int("timeout_errcnt", err_count, exp_err);
        chk_int("timeout_state", dbg_state_o, 0);
    endtask

    task automatic test_stop_err();
        snap();
        send_byte(8'h55, 1'b0);
        idle(20);
        chk_int("stoperr_hunt_fe", fe_cnt - s_fe, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b0);
        idle(20);
        exp_err++;
        chk_int("stoperr_fe", fe_cnt - s_fe, 1);
        chk_int("stoperr_errcnt", err_count, exp_err);
    endtask

    task automatic test_saturate();
        int n;
        n = 255 - exp_err;
        snap();
        for (int i = 0; i < n; i++) begin
            send_byte(8'hA5, 1'b1);
            send_byte(8'h07, 1'b1);
        end
        idle(20);
        chk_int("sat_reach", err_count, 255);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hA5, 1'b1);
            send_byte(8'h07, 1'b1);
        end
        idle(20);
        chk_int("sat_hold", err_count, 255);
        chk_int("sat_fe_pulses", fe_cnt - s_fe, n + 3);
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rx = 1'b0;
        repeat (40) @(posedge clk);
        snap();
        rst_n = 1'b0;
        #1;
        n_checks++; if (data_out !== 48'h0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", data_out); end
        n_checks++; if (err_count !== 8'h0) begin n_fail++; $display("FAIL midrst_errcnt: got %0d expected 0", err_count); end
        n_checks++; if (dbg_state_o !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d expected 0", dbg_state_o); end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        idle(20);
        chk_int("midrst_no_dv", dv_cnt - s_dv, 0);
        exp_err = 0;
        snap();
        send_frame(8'h01, 48'h665544332211, 8'h76);
        idle(20);
        chk_int("midrst_next_dv", dv_cnt - s_dv, 1);
        n_checks++; if (data_out !== 48'h665544332211) begin n_fail++; $display("FAIL midrst_next_data: got %h expected 665544332211", data_out); end
        chk_int("midrst_next_errcnt", err_count, 0);
    endtask

    task automatic test_back_to_back();
        snap();
        send_frame(8'h01, 48'hAABBCCDDEEFF, 8'h01 ^ 8'hFF ^ 8'hEE ^ 8'hDD ^ 8'hCC ^ 8'hBB ^ 8'hAA);
        send_frame(8'h02, 48'h0, 8'h02);
        send_frame(8'h01, 48'h0000000000FE, 8'hFF);
        idle(20);
        chk_int("b2b_dv", dv_cnt - s_dv, 2);
        chk_int("b2b_lm", lm_cnt - s_lm, 1);
        n_checks++; if (data_out !== 48'h0000000000FE) begin n_fail++; $display("FAIL b2b_data: got %h expected 0000000000fe", data_out); end
        chk_int("b2b_errs", (ce_cnt - s_ce) + (fe_cnt - s_fe), 0);
    endtask

    initial begin
        rx = 1'b1;
        rst_n = 1'b0;
        test_reset();
        test_data();
        test_markers();
        test_bad_checksum();
        test_noise();
        test_timeout();
        test_stop_err();
        test_saturate();
        test_reset_mid();
        test_back_to_back();
        chk_int("chk_and_frame_err_same_cycle", both_cnt, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

endmodule
